// File: rtl/rgb_pixel_pipe_pkg.sv
// Shared types for the VGA colour stage: colour triplet, pipe stage payload, constants.
`timescale 1ns/1ps
package rgb_pkg;
    localparam int DEF_CH_W = 4;

    typedef struct packed {
        logic r;
        logic g;
        logic b;
    } rgb_t;

    localparam rgb_t COLOR_WHITE = 3'b111;
    localparam rgb_t COLOR_BLACK = 3'b000;

    // One pipe stage: text/visible decision travels with the colour it was captured with
    typedef struct packed {
        logic sel;
        rgb_t fg;
    } pixel_t;
endpackage

// File: rtl/rgb_pixel_pipe_if.sv
// Pixel-stage bus: asynchronous buttons, timing flags and text bit in; VGA channels out.
`timescale 1ns/1ps
interface rgb_pixel_pipe_if
    import rgb_pkg::*;
#(
    parameter int CH_W = DEF_CH_W
);
    logic            BotonR;
    logic            BotonG;
    logic            BotonB;
    logic            LOAD;
    logic            BLINK_EN;
    logic            BIT_FUENTE;
    logic            H_ON;
    logic            V_ON;
    logic [CH_W-1:0] R;
    logic [CH_W-1:0] G;
    logic [CH_W-1:0] B;
    logic            R2;
    logic            G2;
    logic            B2;
    logic            PHASE;

    modport master (
        output BotonR, BotonG, BotonB, LOAD, BLINK_EN, BIT_FUENTE, H_ON, V_ON,
        input  R, G, B, R2, G2, B2, PHASE
    );

    modport slave (
        input  BotonR, BotonG, BotonB, LOAD, BLINK_EN, BIT_FUENTE, H_ON, V_ON,
        output R, G, B, R2, G2, B2, PHASE
    );
endinterface

// File: rtl/rgb_pixel_pipe_sync_2ff.sv
// Multi-flop synchroniser for one asynchronous level input; clears to 0 on reset.
`timescale 1ns/1ps
module sync_2ff
    import rgb_pkg::*;
#(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_d,
    output logic o_q
);
    logic [STAGES-1:0] r_sh;

    // Shift the raw level through STAGES flops to settle metastability
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_sh <= '0;
        else        r_sh <= {r_sh[STAGES-2:0], i_d};
    end

    assign o_q = r_sh[STAGES-1];
endmodule

// File: rtl/rgb_pixel_pipe.sv
// Registered colour stage: switch-selected foreground commit, frame-counted blink,
// display-zone gating and a PIPE-deep delay to line up with the registered syncs.
`timescale 1ns/1ps
module rgb_pixel_pipe
    import rgb_pkg::*;
#(
    parameter int CH_W         = DEF_CH_W,
    parameter int PIPE         = 2,
    parameter int SYNC_STAGES  = 2,
    parameter int BLINK_FRAMES = 30
) (
    input  logic             CLK,
    input  logic             RESET_N,
    rgb_pixel_pipe_if.slave  bus
);
    // Bit 3..0 = R, G, B switches and LOAD
    logic [3:0] w_async;
    logic [3:0] w_sync;
    logic       r_load_d;
    logic       w_load_edge;
    rgb_t       r_fg;
    logic       r_von_d;
    logic       w_tick;
    logic [7:0] r_cnt;
    logic       r_phase;
    pixel_t     w_cap;
    pixel_t     w_last;

    assign w_async = {bus.BotonR, bus.BotonG, bus.BotonB, bus.LOAD};

    for (genvar i = 0; i < 4; i++) begin : g_sync
        sync_2ff #(.STAGES(SYNC_STAGES)) u_sync (
            .clk   (CLK),
            .rst_n (RESET_N),
            .i_d   (w_async[i]),
            .o_q   (w_sync[i])
        );
    end

    assign w_load_edge = w_sync[0] & ~r_load_d;
    assign w_tick      = r_von_d & ~bus.V_ON;

    // Edge-detect history for LOAD and V_ON
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_load_d <= 1'b0;
            r_von_d  <= 1'b0;
        end else begin
            r_load_d <= w_sync[0];
            r_von_d  <= bus.V_ON;
        end
    end

    // Foreground colour: one commit per LOAD press, sampled from the synced switches
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)         r_fg <= COLOR_WHITE;
        else if (w_load_edge) r_fg <= rgb_t'(w_sync[3:1]);
    end

    // Blink: count frames, toggle phase on wrap; disabling blink wins over a tick
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (!bus.BLINK_EN) begin
            r_cnt   <= '0;
            r_phase <= 1'b1;
        end else if (w_tick) begin
            if (r_cnt == 8'(BLINK_FRAMES - 1)) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt   <= r_cnt + 8'd1;
            end
        end
    end

    // FG is read pre-edge, so a pixel captured on the commit edge keeps the old colour
    assign w_cap.sel = bus.BIT_FUENTE & bus.H_ON & bus.V_ON & r_phase;
    assign w_cap.fg  = r_fg;

    for (genvar i = 0; i < PIPE; i++) begin : g_pipe
        pixel_t r_px;
        pixel_t w_d;
        if (i == 0) begin : g_in
            assign w_d = w_cap;
        end else begin : g_in
            assign w_d = g_pipe[i-1].r_px;
        end
        // Pipe stage register; reset discards any in-flight pixel
        always_ff @(posedge CLK or negedge RESET_N) begin
            if (!RESET_N) r_px <= '0;
            else          r_px <= w_d;
        end
    end

    assign w_last = g_pipe[PIPE-1].r_px;

    assign bus.R     = {CH_W{w_last.sel & w_last.fg.r}};
    assign bus.G     = {CH_W{w_last.sel & w_last.fg.g}};
    assign bus.B     = {CH_W{w_last.sel & w_last.fg.b}};
    assign bus.R2    = bus.R[0];
    assign bus.G2    = bus.G[0];
    assign bus.B2    = bus.B[0];
    assign bus.PHASE = r_phase;
endmodule
